// File: rtl/encoder_scan_arbiter_pkg.sv
// Package shared by the encoder scan arbiter and the encoder counters.
// Holds the default encoder count width and the report FSM state encodings.
package encoder_scan_arbiter_pkg;

    // Default width of an encoder count (and of the reported delta).
    localparam int ENC_VAL_W = 8;

    // Report FSM: IDLE looks for work, PRESENT holds a report on the output port.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_e;

endpackage

// File: rtl/encoder_scan_arbiter_rr_picker.sv
// rr_picker: combinational round-robin first-set search.
//   req      in   NUM_CH  request bits
//   ptr      in   CH_W    highest-priority index (must be < NUM_CH)
//   gnt_idx  out  CH_W    first set request found from ptr upward, wrapping
//   gnt_any  out  1       at least one request is set
module rr_picker #(
    parameter int NUM_CH = 4,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              gnt_any
);

    // idx_rot[k] is the channel examined k-th, i.e. (ptr + k) mod NUM_CH.
    logic [CH_W-1:0]   idx_rot [NUM_CH];
    logic [NUM_CH-1:0] req_rot;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_rot
            logic [CH_W:0] sum;
            assign sum          = {1'b0, ptr} + (CH_W+1)'(gi);
            assign idx_rot[gi]  = (sum >= (CH_W+1)'(NUM_CH)) ? CH_W'(sum - (CH_W+1)'(NUM_CH))
                                                             : CH_W'(sum);
            assign req_rot[gi]  = req[idx_rot[gi]];
        end
    endgenerate

    // Scan from the far end so the lowest rotated position wins.
    always_comb begin
        gnt_any = |req_rot;
        gnt_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                gnt_idx = idx_rot[i];
            end
        end
    end

endmodule

// File: rtl/encoder_scan_arbiter.sv
// encoder_scan_arbiter: shares one report stream among NUM_CH encoder counters.
// Channels whose live count differs from their last reported count are
// granted round-robin; each report carries {channel, value, signed delta}.
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high
//   enable     in   1 = new grants allowed, 0 = only finish the report in flight
//   ch_value   in   live counts, channel i at [i*VAL_W +: VAL_W]
//   out_valid  out  report available
//   out_ready  in   consumer accepts when out_valid & out_ready
//   out_ch     out  granted channel
//   out_value  out  count captured at grant
//   out_delta  out  out_value - last reported count of out_ch (mod 2^VAL_W)
//   pending    out  registered per-channel "moved since last report"
//   overflow   out  sticky: a captured delta was exactly -2^(VAL_W-1)
//   irq        out  only with ENC_SCAN_IRQ_EN defined: registered (|pending) & enable
module encoder_scan_arbiter
    import encoder_scan_arbiter_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int VAL_W  = ENC_VAL_W,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NUM_CH*VAL_W-1:0] ch_value,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CH_W-1:0]         out_ch,
    output logic [VAL_W-1:0]        out_value,
    output logic [VAL_W-1:0]        out_delta,
    output logic [NUM_CH-1:0]       pending,
    output logic                    overflow
`ifdef ENC_SCAN_IRQ_EN
    ,
    output logic                    irq
`endif
);

    // The one delta value whose sign cannot be trusted.
    localparam logic [VAL_W-1:0] DELTA_AMBIG = {1'b1, {(VAL_W-1){1'b0}}};

    state_e            state_reg;
    logic [CH_W-1:0]   rr_ptr_reg;
    logic [VAL_W-1:0]  last_reported_reg [NUM_CH];
    logic [VAL_W-1:0]  live [NUM_CH];
    logic [NUM_CH-1:0] pending_next;
    logic              handshake;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic [VAL_W-1:0]  grant_value;
    logic [VAL_W-1:0]  grant_delta;
    logic [CH_W-1:0]   rr_ptr_next;

    assign handshake = (state_reg == ST_PRESENT) && out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign live[gi] = ch_value[gi*VAL_W +: VAL_W];
            // The channel being accepted this edge still compares against its old
            // last_reported value, so its bit is masked to avoid a stale regrant.
            assign pending_next[gi] = (live[gi] != last_reported_reg[gi])
                                      && !(handshake && (out_ch == CH_W'(gi)));
        end
    endgenerate

    rr_picker #(
        .NUM_CH (NUM_CH)
    ) u_picker (
        .req     (pending),
        .ptr     (rr_ptr_reg),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign grant_value = live[gnt_idx];
    assign grant_delta = grant_value - last_reported_reg[gnt_idx];
    assign rr_ptr_next = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_value  <= '0;
            out_delta  <= '0;
            pending    <= '0;
            overflow   <= 1'b0;
            rr_ptr_reg <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                last_reported_reg[i] <= '0;
            end
`ifdef ENC_SCAN_IRQ_EN
            irq        <= 1'b0;
`endif
        end else begin
            pending <= pending_next;
`ifdef ENC_SCAN_IRQ_EN
            irq     <= (|pending) && enable;
`endif
            case (state_reg)
                ST_IDLE: begin
                    if (enable && gnt_any) begin
                        out_ch     <= gnt_idx;
                        out_value  <= grant_value;
                        out_delta  <= grant_delta;
                        out_valid  <= 1'b1;
                        rr_ptr_reg <= rr_ptr_next;
                        if (grant_delta == DELTA_AMBIG) begin
                            overflow <= 1'b1;
                        end
                        state_reg  <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    // Output fields are left untouched while stalled.
                    if (out_ready) begin
                        out_valid                 <= 1'b0;
                        last_reported_reg[out_ch] <= out_value;
                        state_reg                 <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_scan_arbiter.sv
// Self-checking bench for encoder_scan_arbiter (NUM_CH=4, VAL_W=8).
// A behavioural model predicts every output each cycle; directed scenarios add
// constant expectations for the documented cases, then a randomized phase runs.
module tb_encoder_scan_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  chv [4];
    logic [31:0] ch_value;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;
    logic [7:0]  out_value;
    logic [7:0]  out_delta;
    logic [3:0]  pending;
    logic        overflow;
`ifdef ENC_SCAN_IRQ_EN
    logic        irq;
`endif

    int checks   = 0;
    int failures = 0;

    assign ch_value = {chv[3], chv[2], chv[1], chv[0]};

    always #5 clk = ~clk;

    encoder_scan_arbiter #(
        .NUM_CH (4),
        .VAL_W  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .ch_value  (ch_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_value (out_value),
        .out_delta (out_delta),
        .pending   (pending),
        .overflow  (overflow)
`ifdef ENC_SCAN_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    // Reference model state.
    logic [7:0] m_last [4];
    logic [3:0] m_pend = '0;
    bit         m_busy = 0;
    int         m_ch   = 0;
    logic [7:0] m_val  = '0;
    logic [7:0] m_dl   = '0;
    int         m_ptr  = 0;
    bit         m_ovf  = 0;
    bit         m_irq  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the specified behaviour, using the inputs as driven.
    task automatic model_edge();
        logic [3:0] np;
        bit hs;
        if (reset) begin
            for (int i = 0; i < 4; i++) m_last[i] = 8'h00;
            m_pend = '0; m_busy = 0; m_ch = 0; m_val = '0; m_dl = '0;
            m_ptr = 0; m_ovf = 0; m_irq = 0;
            return;
        end
        hs = m_busy && out_ready;
        for (int i = 0; i < 4; i++)
            np[i] = (chv[i] != m_last[i]) && !(hs && m_ch == i);
        m_irq = (m_pend != 0) && enable;
        if (!m_busy) begin
            if (enable) begin
                for (int off = 0; off < 4; off++) begin
                    int c;
                    c = (m_ptr + off) % 4;
                    if (m_pend[c]) begin
                        m_ch   = c;
                        m_val  = chv[c];
                        m_dl   = chv[c] - m_last[c];
                        m_busy = 1;
                        m_ptr  = (c + 1) % 4;
                        if (m_dl == 8'h80) m_ovf = 1;
                        break;
                    end
                end
            end
        end else if (out_ready) begin
            m_last[m_ch] = m_val;
            m_busy = 0;
        end
        m_pend = np;
    endtask

    task automatic compare_all();
        check_val("valid", out_valid, m_busy);
        check_val("ch", out_ch, m_ch);
        check_val("value", out_value, m_val);
        check_val("delta", out_delta, m_dl);
        check_val("pending", pending, m_pend);
        check_val("overflow", overflow, m_ovf);
`ifdef ENC_SCAN_IRQ_EN
        check_val("irq", irq, m_irq);
`endif
    endtask

    // Called just after a falling edge; advances one cycle and compares.
    task automatic tick();
        if (out_valid && out_ready && !reset)
            $display("report ch=%0d value=%02h delta=%02h", out_ch, out_value, out_delta);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Wait (bounded) for a report, check it against constants, accept it if ready.
    task automatic wait_report(input string tag, input int ch, input int val, input int dl);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check_val({tag, "_seen"}, out_valid, 1);
        check_val({tag, "_ch"}, out_ch, ch);
        check_val({tag, "_value"}, out_value, val);
        check_val({tag, "_delta"}, out_delta, dl);
        if (out_ready) tick();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) chv[i] = 8'h00;
        @(negedge clk);
        do_reset();

        // 1: idle with no movement
        for (int k = 0; k < 20; k++) begin
            tick();
            check_val("s1_valid", out_valid, 0);
            check_val("s1_pending", pending, 0);
            check_val("s1_overflow", overflow, 0);
        end

        // 2: single channel moves, two-cycle latency, no regrant
        chv[1] = 8'd5;
        tick();
        check_val("s2_not_yet", out_valid, 0);
        tick();
        check_val("s2_latency", out_valid, 1);
        wait_report("s2", 1, 5, 5);
        for (int k = 0; k < 6; k++) begin
            tick();
            check_val("s2_no_regrant", out_valid, 0);
            check_val("s2_pending1", pending[1], 0);
        end

        // 3: round-robin ordering from a fresh pointer
        do_reset();
        chv[0] = 8'd3; chv[1] = 8'd0; chv[2] = 8'd7; chv[3] = 8'd1;
        wait_report("s3a", 0, 3, 3);
        wait_report("s3b", 2, 7, 7);
        wait_report("s3c", 3, 1, 1);
        for (int k = 0; k < 3; k++) tick();
        chv[0] = 8'd4; chv[3] = 8'd2;
        wait_report("s3d", 0, 4, 1);
        wait_report("s3e", 3, 2, 1);

        // 4: stalled report holds its fields; movement during hold re-pends
        do_reset();
        for (int i = 0; i < 4; i++) chv[i] = 8'h00;
        out_ready = 1'b0;
        chv[2] = 8'd7;
        wait_report("s4a", 2, 7, 7);
        for (int k = 0; k < 10; k++) begin
            if (k == 3) chv[2] = 8'd9;
            tick();
            check_val("s4_hold_valid", out_valid, 1);
            check_val("s4_hold_value", out_value, 7);
        end
        out_ready = 1'b1;
        tick();
        wait_report("s4b", 2, 9, 2);

        // 5: delta wrap and ambiguous delta
        do_reset();
        for (int i = 0; i < 4; i++) chv[i] = 8'h00;
        tick();
        chv[1] = 8'hFE;
        wait_report("s5a", 1, 8'hFE, 8'hFE);
        chv[1] = 8'h02;
        wait_report("s5b", 1, 8'h02, 8'h04);
        check_val("s5_no_ovf", overflow, 0);
        chv[1] = 8'h82;
        wait_report("s5c", 1, 8'h82, 8'h80);
        for (int k = 0; k < 5; k++) tick();
        check_val("s5_ovf_sticky", overflow, 1);

        // 6: enable low blocks grants; reset during a stalled report
        do_reset();
        check_val("s6_ovf_cleared", overflow, 0);
        for (int i = 0; i < 4; i++) chv[i] = 8'h00;
        enable = 1'b0; out_ready = 1'b0;
        chv[3] = 8'd4;
        for (int k = 0; k < 10; k++) tick();
        check_val("s6_no_grant", out_valid, 0);
        check_val("s6_pending", pending, 4'b1000);
`ifdef ENC_SCAN_IRQ_EN
        check_val("s6_irq", irq, 0);
`endif
        enable = 1'b1;
        wait_report("s6a", 3, 4, 4);
        for (int k = 0; k < 3; k++) tick();
        reset = 1'b1;
        tick();
        check_val("s6_reset_valid", out_valid, 0);
        check_val("s6_reset_pending", pending, 0);
        reset = 1'b0;
        tick();
        check_val("s6_repend", pending, 4'b1000);
        out_ready = 1'b1;
        wait_report("s6b", 3, 4, 4);

        // Randomized phase, checked every cycle by the model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                int c;
                c = $urandom_range(0, 3);
                if ($urandom_range(0, 1) == 0) chv[c] = chv[c] + 8'($urandom_range(1, 3));
                else                           chv[c] = 8'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            enable    = ($urandom_range(0, 15) != 0);
            reset     = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
